io_responder: RTL and testbench
===============================

Name: io_responder

Overview:
- Memory-mapped I/O responder on the CPU side of the I/O bus.
- The control unit asserts IORead/IOWrite for any load or store whose address is in 0xFFFFFC00–0xFFFFFFFF; this block services those accesses.
- It holds an LED output register, a synchronized switch input port and a programmable down-counter timer.
- It returns registered read data to the memorio multiplexer.

Parameters:
- LED_WIDTH, 24, number of LED outputs (fixed map below assumes 24)
- SW_WIDTH, 24, number of switch inputs (fixed map below assumes 24)
- TIMER_WIDTH, 32, timer counter/reload width

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- IORead  in  1  I/O read strobe from control unit, one cycle per access
- IOWrite  in  1  I/O write strobe from control unit, one cycle per access
- addr  in  10  Alu_Result[9:0], offset within the I/O page
- wdata  in  32  store data (rt value)
- rdata  out  32  registered read data
- switch_in  in  SW_WIDTH  raw asynchronous board switches
- led_out  out  LED_WIDTH  LED drive
- timer_irq  out  1  level, equals the timer done flag

Behaviour:
- Address map (offsets):
  - 0x20 TCTRL R/W: bit0 enable, bit1 periodic; other bits read 0.
  - 0x24 TCOUNT: a write loads both reload and count with wdata; a read returns the current count.
  - 0x28 TSTAT R: bit0 done; a read clears done.
  - 0x60 LEDLO R/W: led[15:0] <= wdata[15:0].
  - 0x62 LEDHI R/W: led[23:16] <= wdata[7:0].
  - 0x70 SWLO R: {16'b0, sw_sync[15:0]}.
  - 0x72 SWHI R: {24'b0, sw_sync[23:16]}.
  - Unmapped offsets read 0x00000000; writes to them are ignored.
- Reset (reset==0 at a clock edge): rdata, led_out, both switch sync stages, TCTRL, count, reload, done and timer_irq all go to 0.
- Read latency: rdata updates on the edge where IORead==1 and is valid the following cycle. rdata holds its value when IORead==0.
- Write latency: the register updates on the edge where IOWrite==1; the new value is visible to a read issued in the next cycle.
- If IORead and IOWrite are both 1 in the same cycle, the access is a write only; rdata is unchanged.
- Switches pass through a 2-flop synchronizer, so reads see a switch change 2 cycles after it occurs.
- Timer, evaluated each edge in this priority order:
  1. A TCOUNT write loads count and reload; no decrement that cycle.
  2. Otherwise, if enable==1 and count>1: count <= count-1.
  3. Otherwise, if enable==1 and count==1: done <= 1, then:
     - periodic==1: count <= reload; if reload==0, enable <= 0.
     - periodic==0: count <= 0 and enable <= 0.
  4. enable==1 with count==0: no change, done is not set.
- Simultaneous events:
  - TSTAT read in the same cycle as expiry: done ends at 1 (set beats clear). The rdata returned for that read shows the pre-edge value of done.
  - TCTRL write in the same cycle as expiry: the written enable and periodic values win over the auto-clear.
- Wrap-around: count never goes below 0. A load of 0xFFFFFFFF with enable set expires after 2^32−1 cycles.
- Reset asserted mid-count discards all timer state; no done pulse is generated.

Decomposition:
- Package io_map_pkg:
  - address offset localparams: TCTRL, TCOUNT, TSTAT, LEDLO, LEDHI, SWLO, SWHI
  - TCTRL bit indices: EN=0, PER=1
- Sub-module io_timer holds count, reload, enable, periodic and done; load and clear strobes arrive from the decode logic.
- The switch synchronizer and LED register stay inline.

Test Plan:
- LED: IOWrite addr=0x60 wdata=0x0000A5A5, then addr=0x62 wdata=0x0000003C -> led_out=0x3CA5A5; IORead 0x60 -> rdata=0x0000A5A5 the next cycle.
- Switch: switch_in=0x123456 -> IORead 0x70 issued 3 or more cycles later returns 0x00003456; 0x72 returns 0x00000012; a read issued 1 cycle after the change returns the old value.
- One-shot: write TCOUNT=5, TCTRL=0x1 -> done=1 and timer_irq=1 exactly 5 cycles after the TCTRL write edge; count=0, TCTRL reads 0x0; a TSTAT read returns 0x1, then done=0.
- Periodic: TCOUNT=3, TCTRL=0x3 -> timer_irq sets every 3 cycles; a TSTAT read coincident with an expiry leaves done=1.
- Unmapped/priority: IOWrite to 0x40 changes nothing; IORead 0x40 -> rdata=0; IORead and IOWrite both 1 at 0x60 -> LED written, rdata unchanged.
- Reset: assert reset=0 for one cycle mid-count (count=100) -> count=0, done=0, led_out=0, rdata=0 on the next cycle; the timer stays idle afterwards.

Source files
------------

// File: rtl/io_map_pkg.sv
// io_map_pkg: register offsets within the I/O page and timer control bit positions
package io_map_pkg;
    localparam logic [9:0] TCTRL  = 10'h020;
    localparam logic [9:0] TCOUNT = 10'h024;
    localparam logic [9:0] TSTAT  = 10'h028;
    localparam logic [9:0] LEDLO  = 10'h060;
    localparam logic [9:0] LEDHI  = 10'h062;
    localparam logic [9:0] SWLO   = 10'h070;
    localparam logic [9:0] SWHI   = 10'h072;
    localparam int EN  = 0;
    localparam int PER = 1;
endpackage

// File: rtl/io_timer.sv
// io_timer: programmable down-counter with one-shot/periodic reload and a sticky done flag
module io_timer #(
    parameter int TIMER_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic [TIMER_WIDTH-1:0] load_val,
    input  logic                   ctrl_we,
    input  logic [1:0]             ctrl_val,
    input  logic                   clear,
    output logic [TIMER_WIDTH-1:0] count,
    output logic                   enable,
    output logic                   periodic,
    output logic                   done
);
    import io_map_pkg::*;

    logic [TIMER_WIDTH-1:0] reload;
    logic                   expire;

    assign expire = !load && enable && count == TIMER_WIDTH'(1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count    <= '0;
            reload   <= '0;
            enable   <= 1'b0;
            periodic <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (load) begin
                count  <= load_val;
                reload <= load_val;
            end else if (enable && count > TIMER_WIDTH'(1)) begin
                count <= count - TIMER_WIDTH'(1);
            end else if (expire) begin
                count <= periodic ? reload : '0;
                if (!periodic || reload == '0) enable <= 1'b0;
            end
            // A control write lands after the auto-clear so software intent wins
            if (ctrl_we) begin
                enable   <= ctrl_val[EN];
                periodic <= ctrl_val[PER];
            end
            done <= expire | (done & ~clear);
        end
    end
endmodule

// File: rtl/io_responder.sv
// io_responder: memory-mapped I/O page with LED register, synchronized switches and a timer;
// returns registered read data to the memorio multiplexer.
module io_responder #(
    parameter int LED_WIDTH   = 24,
    parameter int SW_WIDTH    = 24,
    parameter int TIMER_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 IORead,
    input  logic                 IOWrite,
    input  logic [9:0]           addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    input  logic [SW_WIDTH-1:0]  switch_in,
    output logic [LED_WIDTH-1:0] led_out,
    output logic                 timer_irq
);
    import io_map_pkg::*;

    logic                   rd, wr;
    logic [SW_WIDTH-1:0]    sw_meta, sw_sync;
    logic [TIMER_WIDTH-1:0] count;
    logic                   enable, periodic, done;
    logic [31:0]            rd_val;

    // A simultaneous read and write is treated purely as a write
    assign wr = IOWrite;
    assign rd = IORead & ~IOWrite;
    assign timer_irq = done;

    assign rd_val = addr == TCTRL  ? 32'({periodic, enable}) :
                    addr == TCOUNT ? 32'(count) :
                    addr == TSTAT  ? 32'(done) :
                    addr == LEDLO  ? 32'(led_out[15:0]) :
                    addr == LEDHI  ? 32'(led_out[23:16]) :
                    addr == SWLO   ? 32'(sw_sync[15:0]) :
                    addr == SWHI   ? 32'(sw_sync[23:16]) : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata   <= '0;
            led_out <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= switch_in;
            sw_sync <= sw_meta;
            if (rd) rdata <= rd_val;
            if (wr && addr == LEDLO) led_out[15:0] <= wdata[15:0];
            if (wr && addr == LEDHI) led_out[23:16] <= wdata[7:0];
        end
    end

    io_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (wr && addr == TCOUNT),
        .load_val (wdata[TIMER_WIDTH-1:0]),
        .ctrl_we  (wr && addr == TCTRL),
        .ctrl_val (wdata[1:0]),
        .clear    (rd && addr == TSTAT),
        .count    (count),
        .enable   (enable),
        .periodic (periodic),
        .done     (done)
    );
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: directed vector table for the register map plus hand-written timer,
// switch-synchronizer and reset sequences.
module tb_io_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        IORead = 1'b0;
    logic        IOWrite = 1'b0;
    logic [9:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [23:0] switch_in = '0;
    logic [23:0] led_out;
    logic        timer_irq;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [23:0] exp_led;
    } vec_t;

    vec_t vecs[18];

    io_responder dut (
        .clock     (clock),
        .reset     (reset),
        .IORead    (IORead),
        .IOWrite   (IOWrite),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .switch_in (switch_in),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One bus cycle: drive mid-cycle, let the edge happen, return just after it
    task automatic io(input logic r, input logic w, input logic [9:0] a, input logic [31:0] d);
        @(negedge clock);
        IORead = r;
        IOWrite = w;
        addr = a;
        wdata = d;
        @(posedge clock);
        #1;
        IORead = 1'b0;
        IOWrite = 1'b0;
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 10'h060, 32'h0000A5A5, 32'h00000000, 24'h00A5A5};
        vecs[1]  = '{1'b0, 1'b1, 10'h062, 32'h0000003C, 32'h00000000, 24'h3CA5A5};
        vecs[2]  = '{1'b1, 1'b0, 10'h060, 32'h0,        32'h0000A5A5, 24'h3CA5A5};
        vecs[3]  = '{1'b1, 1'b0, 10'h062, 32'h0,        32'h0000003C, 24'h3CA5A5};
        vecs[4]  = '{1'b0, 1'b1, 10'h040, 32'hFFFFFFFF, 32'h0000003C, 24'h3CA5A5};
        vecs[5]  = '{1'b1, 1'b0, 10'h040, 32'h0,        32'h00000000, 24'h3CA5A5};
        vecs[6]  = '{1'b1, 1'b0, 10'h062, 32'h0,        32'h0000003C, 24'h3CA5A5};
        vecs[7]  = '{1'b1, 1'b0, 10'h022, 32'h0,        32'h00000000, 24'h3CA5A5};
        vecs[8]  = '{1'b1, 1'b1, 10'h060, 32'h00001234, 32'h00000000, 24'h3C1234};
        vecs[9]  = '{1'b1, 1'b0, 10'h060, 32'h0,        32'h00001234, 24'h3C1234};
        vecs[10] = '{1'b0, 1'b1, 10'h062, 32'hFFFFFF81, 32'h00001234, 24'h811234};
        vecs[11] = '{1'b1, 1'b0, 10'h062, 32'h0,        32'h00000081, 24'h811234};
        vecs[12] = '{1'b0, 1'b1, 10'h020, 32'h00000002, 32'h00000081, 24'h811234};
        vecs[13] = '{1'b1, 1'b0, 10'h020, 32'h0,        32'h00000002, 24'h811234};
        vecs[14] = '{1'b0, 1'b1, 10'h020, 32'hFFFFFFFC, 32'h00000002, 24'h811234};
        vecs[15] = '{1'b1, 1'b0, 10'h020, 32'h0,        32'h00000000, 24'h811234};
        vecs[16] = '{1'b1, 1'b0, 10'h024, 32'h0,        32'h00000000, 24'h811234};
        vecs[17] = '{1'b1, 1'b0, 10'h028, 32'h0,        32'h00000000, 24'h811234};

        repeat (2) idle();
        check("reset rdata", rdata, 32'h0);
        check("reset led", 32'(led_out), 32'h0);
        check("reset irq", 32'(timer_irq), 32'h0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            io(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d led", i), 32'(led_out), 32'(vecs[i].exp_led));
        end

        // Switch synchronizer: a read one cycle after the change still sees the old value
        @(negedge clock);
        switch_in = 24'h123456;
        io(1'b1, 1'b0, 10'h070, 32'h0);
        check("sw early", rdata, 32'h0);
        idle();
        io(1'b1, 1'b0, 10'h070, 32'h0);
        check("sw lo", rdata, 32'h00003456);
        io(1'b1, 1'b0, 10'h072, 32'h0);
        check("sw hi", rdata, 32'h00000012);

        // One-shot: expiry exactly 5 edges after the enabling write
        io(1'b0, 1'b1, 10'h024, 32'd5);
        io(1'b0, 1'b1, 10'h020, 32'h1);
        for (int i = 1; i <= 5; i++) begin
            idle();
            check($sformatf("oneshot irq t%0d", i), 32'(timer_irq), (i == 5) ? 32'h1 : 32'h0);
        end
        io(1'b1, 1'b0, 10'h024, 32'h0);
        check("oneshot count", rdata, 32'h0);
        io(1'b1, 1'b0, 10'h020, 32'h0);
        check("oneshot tctrl", rdata, 32'h0);
        io(1'b1, 1'b0, 10'h028, 32'h0);
        check("oneshot tstat", rdata, 32'h1);
        check("oneshot cleared", 32'(timer_irq), 32'h0);
        repeat (4) idle();
        check("oneshot stays idle", 32'(timer_irq), 32'h0);

        // Periodic with reload 3
        io(1'b0, 1'b1, 10'h024, 32'd3);
        io(1'b0, 1'b1, 10'h020, 32'h3);
        for (int i = 1; i <= 3; i++) begin
            idle();
            check($sformatf("per irq t%0d", i), 32'(timer_irq), (i == 3) ? 32'h1 : 32'h0);
        end
        io(1'b1, 1'b0, 10'h028, 32'h0);
        check("per tstat", rdata, 32'h1);
        check("per cleared", 32'(timer_irq), 32'h0);
        idle();
        check("per mid", 32'(timer_irq), 32'h0);
        io(1'b1, 1'b0, 10'h028, 32'h0);
        check("coincident tstat rdata", rdata, 32'h0);
        check("coincident done kept", 32'(timer_irq), 32'h1);
        io(1'b1, 1'b0, 10'h028, 32'h0);
        check("per tstat2", rdata, 32'h1);
        check("per cleared2", 32'(timer_irq), 32'h0);
        idle();
        check("per mid2", 32'(timer_irq), 32'h0);
        idle();
        check("per expire3", 32'(timer_irq), 32'h1);
        io(1'b1, 1'b0, 10'h028, 32'h0);
        check("per tstat3", rdata, 32'h1);
        idle();
        // Control write coincident with expiry: periodic reload happens, written one-shot mode wins
        io(1'b0, 1'b1, 10'h020, 32'h1);
        check("ctrl at expiry irq", 32'(timer_irq), 32'h1);
        io(1'b1, 1'b0, 10'h020, 32'h0);
        check("ctrl at expiry tctrl", rdata, 32'h1);
        idle();
        io(1'b1, 1'b0, 10'h024, 32'h0);
        check("count before oneshot expiry", rdata, 32'h1);
        io(1'b1, 1'b0, 10'h020, 32'h0);
        check("tctrl after oneshot expiry", rdata, 32'h0);
        io(1'b1, 1'b0, 10'h024, 32'h0);
        check("count after oneshot expiry", rdata, 32'h0);

        // Reset mid-count
        io(1'b0, 1'b1, 10'h024, 32'd100);
        io(1'b0, 1'b1, 10'h020, 32'h1);
        io(1'b0, 1'b1, 10'h060, 32'h0000FFFF);
        io(1'b1, 1'b0, 10'h060, 32'h0);
        check("pre-reset rdata", rdata, 32'h0000FFFF);
        check("pre-reset irq", 32'(timer_irq), 32'h1);
        repeat (3) idle();
        @(negedge clock);
        reset = 1'b0;
        idle();
        check("mid reset rdata", rdata, 32'h0);
        check("mid reset led", 32'(led_out), 32'h0);
        check("mid reset irq", 32'(timer_irq), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        io(1'b1, 1'b0, 10'h024, 32'h0);
        check("post reset count", rdata, 32'h0);
        io(1'b1, 1'b0, 10'h020, 32'h0);
        check("post reset tctrl", rdata, 32'h0);
        repeat (120) idle();
        check("post reset idle irq", 32'(timer_irq), 32'h0);
        io(1'b1, 1'b0, 10'h024, 32'h0);
        check("post reset idle count", rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
